// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART word link: FSM encodings, 8N1 frame
// constants and a helper that sizes counters from their terminal count.
package uart_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_ACK
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  localparam int   BITS        = 8;
  localparam int   FRAME_LEN   = BITS + 2;
  localparam int   FRAME_IDX_W = $clog2(FRAME_LEN);
  localparam int   BIT_IDX_W   = $clog2(BITS);

  // Width of a counter that must hold the values 0 .. count-1.
  function automatic int cnt_w(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises the serial line, detects the start edge,
// samples every bit at mid-bit and reports either a good byte or a bad stop bit.
module uart_rx_byte
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       idle
);

  localparam int               CNT_W     = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                 sync1, sync2, prev;
  rx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [7:0]           shreg;

  // Two-flop synchroniser plus a delayed copy; resets to the idle-high level so no false start edge appears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Frame FSM: start edge, half-bit start check, then one sample per bit period centred in each bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (prev && !sync2) begin
            state   <= RX_START;
            clk_cnt <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= (sync2 == START_BIT) ? RX_DATA : RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {sync2, shreg[7:1]};
            if (bit_idx == BIT_IDX_W'(BITS - 1)) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= RX_IDLE;
            if (sync2 == STOP_BIT) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign idle = (state == RX_IDLE);

endmodule

// File: rtl/uart_word_link.sv
// Word-level UART link end: sends a DATA_W-bit word as DATA_W/8 8N1 bytes with
// ack/timeout/retry, and reassembles received words, acknowledging good ones.
module uart_word_link
  import uart_link_pkg::*;
#(
  parameter int DATA_W       = 128,
  parameter int CLKS_PER_BIT = 434,
  parameter int ACK_TIMEOUT  = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int GAP_BITS     = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_fail,
  output logic              UART_TX,
  input  logic              UART_RX,
  input  logic              ack_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err
);

  localparam int NBYTES    = DATA_W / 8;
  localparam int BYTE_W    = cnt_w(NBYTES);
  localparam int CNT_W     = cnt_w(CLKS_PER_BIT);
  localparam int TO_W      = cnt_w(ACK_TIMEOUT);
  localparam int RETRY_W   = cnt_w(MAX_RETRY + 1);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = cnt_w(GAP_LIMIT);

  localparam logic [BYTE_W-1:0]      LAST_BYTE  = BYTE_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]       BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]        TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0]     RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]       GAP_LAST   = GAP_W'(GAP_LIMIT - 1);
  localparam logic [FRAME_IDX_W-1:0] FRAME_LAST = FRAME_IDX_W'(FRAME_LEN - 1);
  localparam logic [FRAME_IDX_W-1:0] FRAME_STOP = FRAME_IDX_W'(BITS);

  tx_state_t              tx_state;
  logic [DATA_W-1:0]      tx_word;
  logic [BYTE_W-1:0]      tx_byte_idx;
  logic [FRAME_IDX_W-1:0] frame_idx;
  logic [CNT_W-1:0]       tx_clk_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [RETRY_W-1:0]     retry_cnt;
  logic [7:0]             cur_byte;
  logic                   ack_s1, ack_s2, ack_prev, ack_rise;

  logic [7:0]        rx_byte;
  logic              byte_valid, stop_err, rx_idle, word_done;
  logic [DATA_W-1:0] word_buf, assembled;
  logic [BYTE_W-1:0] rx_byte_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  ack_cnt;

  assign cur_byte = tx_word[tx_byte_idx*8 +: 8];
  assign ack_rise = ack_s2 & ~ack_prev;

  // Synchronise the peer acknowledge and keep one delayed copy for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_s1   <= ack_in;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
    end
  end

  // TX FSM: serialise the latched word, then wait for an ack edge or time out and resend; ack beats timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_word     <= '0;
      tx_byte_idx <= '0;
      frame_idx   <= '0;
      tx_clk_cnt  <= '0;
      to_cnt      <= '0;
      retry_cnt   <= '0;
      UART_TX     <= STOP_BIT;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_fail     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_fail <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_word     <= tx_data;
            retry_cnt   <= '0;
            tx_byte_idx <= '0;
            frame_idx   <= '0;
            tx_clk_cnt  <= '0;
            UART_TX     <= START_BIT;
            tx_busy     <= 1'b1;
            tx_state    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= '0;
            if (frame_idx == FRAME_LAST) begin
              frame_idx <= '0;
              if (tx_byte_idx == LAST_BYTE) begin
                UART_TX  <= STOP_BIT;
                to_cnt   <= '0;
                tx_state <= TX_WAIT_ACK;
              end else begin
                tx_byte_idx <= tx_byte_idx + 1'b1;
                UART_TX     <= START_BIT;
              end
            end else begin
              frame_idx <= frame_idx + 1'b1;
              UART_TX   <= (frame_idx == FRAME_STOP) ? STOP_BIT : cur_byte[frame_idx[BIT_IDX_W-1:0]];
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
          end
        end
        TX_WAIT_ACK: begin
          if (ack_rise) begin
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt   <= retry_cnt + 1'b1;
              tx_byte_idx <= '0;
              frame_idx   <= '0;
              tx_clk_cnt  <= '0;
              UART_TX     <= START_BIT;
              tx_state    <= TX_SEND;
            end else begin
              tx_fail  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_state <= TX_IDLE;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clock     (clock),
    .reset     (reset),
    .serial_in (UART_RX),
    .byte_data (rx_byte),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .idle      (rx_idle)
  );

  assign word_done = byte_valid && (rx_byte_idx == LAST_BYTE);

  // The completed word is the buffer with the final byte dropped into its slot.
  always_comb begin
    assembled = word_buf;
    assembled[rx_byte_idx*8 +: 8] = rx_byte;
  end

  // Word assembly: collect bytes, publish complete words, and drop partial words on a bad stop bit or a long gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_buf     <= '0;
      rx_byte_idx  <= '0;
      gap_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (byte_valid) begin
        gap_cnt                      <= '0;
        word_buf[rx_byte_idx*8 +: 8] <= rx_byte;
        if (word_done) begin
          rx_data     <= assembled;
          rx_valid    <= 1'b1;
          rx_byte_idx <= '0;
        end else begin
          rx_byte_idx <= rx_byte_idx + 1'b1;
        end
      end else if (stop_err) begin
        rx_byte_idx  <= '0;
        gap_cnt      <= '0;
        rx_frame_err <= 1'b1;
      end else if ((rx_byte_idx != '0) && rx_idle) begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt      <= '0;
          rx_byte_idx  <= '0;
          rx_frame_err <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Ack pulse generator: one bit-time high per good word, restarting if another word lands mid-pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_out <= 1'b0;
      ack_cnt <= '0;
    end else if (word_done) begin
      ack_out <= 1'b1;
      ack_cnt <= '0;
    end else if (ack_out) begin
      if (ack_cnt == BIT_LAST) ack_out <= 1'b0;
      else ack_cnt <= ack_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_word_link.sv
// Two cross-wired link ends with a scoreboard of expected words per direction,
// plus line-level fault injection for framing and gap errors.
module tb_uart_word_link;

  localparam int DW          = 32;
  localparam int CPB         = 4;
  localparam int ATO         = 200;
  localparam int MR          = 2;
  localparam int GB          = 40;
  localparam int NB          = DW / 8;
  localparam int WORD_CYCLES = NB * 10 * CPB;
  localparam int ATTEMPT     = WORD_CYCLES + ATO;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [DW-1:0] a_tx_data = '0, b_tx_data = '0;
  logic          a_tx_wr = 1'b0, b_tx_wr = 1'b0;
  logic          a_tx_busy, a_tx_done, a_tx_fail, a_uart_tx, a_ack_out, a_rx_valid, a_rx_frame_err;
  logic          b_tx_busy, b_tx_done, b_tx_fail, b_uart_tx, b_ack_out, b_rx_valid, b_rx_frame_err;
  logic [DW-1:0] a_rx_data, b_rx_data;

  logic ack_cut = 1'b0, force_low = 1'b0, inject_en = 1'b0, inject_line = 1'b1;
  logic a_rx_line, b_rx_line, a_ack_in, b_ack_in;

  assign b_rx_line = inject_en ? inject_line : (a_uart_tx & ~force_low);
  assign a_rx_line = b_uart_tx;
  assign a_ack_in  = b_ack_out & ~ack_cut;
  assign b_ack_in  = a_ack_out;

  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] q_a[$], q_b[$];
  int b_valid_times[$];
  int a_rx_cnt = 0, b_rx_cnt = 0, a_fe_cnt = 0, b_fe_cnt = 0, b_ack_cnt = 0;
  int a_ack_len = 0, b_ack_len = 0;

  uart_word_link #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ACK_TIMEOUT(ATO), .MAX_RETRY(MR), .GAP_BITS(GB)) dut_a (
    .clock(clock), .reset(reset), .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_busy(a_tx_busy),
    .tx_done(a_tx_done), .tx_fail(a_tx_fail), .UART_TX(a_uart_tx), .UART_RX(a_rx_line),
    .ack_in(a_ack_in), .ack_out(a_ack_out), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_frame_err(a_rx_frame_err));

  uart_word_link #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ACK_TIMEOUT(ATO), .MAX_RETRY(MR), .GAP_BITS(GB)) dut_b (
    .clock(clock), .reset(reset), .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_busy(b_tx_busy),
    .tx_done(b_tx_done), .tx_fail(b_tx_fail), .UART_TX(b_uart_tx), .UART_RX(b_rx_line),
    .ack_in(b_ack_in), .ack_out(b_ack_out), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_frame_err(b_rx_frame_err));

  // Free-running clock and a cycle counter used for latency measurements.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every delivered word must match the oldest expected word for that direction.
  always @(negedge clock) begin
    if (reset) begin
      a_ack_len = 0;
      b_ack_len = 0;
    end else begin
      if (b_rx_valid) begin
        b_rx_cnt++;
        b_valid_times.push_back(cyc);
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL b_unexpected_word actual=%0h expected=none", b_rx_data);
        end else checkOutput("b_rx_data", b_rx_data, q_b.pop_front());
      end
      if (a_rx_valid) begin
        a_rx_cnt++;
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL a_unexpected_word actual=%0h expected=none", a_rx_data);
        end else checkOutput("a_rx_data", a_rx_data, q_a.pop_front());
      end
      if (a_rx_frame_err) a_fe_cnt++;
      if (b_rx_frame_err) b_fe_cnt++;
      if (b_ack_out) b_ack_len++;
      else if (b_ack_len != 0) begin
        checkOutput("b_ack_width", b_ack_len, CPB);
        b_ack_cnt++;
        b_ack_len = 0;
      end
      if (a_ack_out) a_ack_len++;
      else if (a_ack_len != 0) begin
        checkOutput("a_ack_width", a_ack_len, CPB);
        a_ack_len = 0;
      end
    end
  end

  // Issue one tx_wr pulse; 'copies' is how many times the peer is expected to receive the word.
  task automatic applyStimulus(input bit from_b, input logic [DW-1:0] word, input int copies);
    @(negedge clock);
    if (from_b) begin b_tx_data = word; b_tx_wr = 1'b1; end
    else begin a_tx_data = word; a_tx_wr = 1'b1; end
    for (int i = 0; i < copies; i++) begin
      if (from_b) q_a.push_back(word); else q_b.push_back(word);
    end
    @(negedge clock);
    if (from_b) b_tx_wr = 1'b0; else a_tx_wr = 1'b0;
  endtask

  task automatic waitDone(input bit on_b, input bit want_done, input int limit, input string name);
    bit got_done = 1'b0, got_fail = 1'b0;
    int n = 0;
    while (!got_done && !got_fail && n < limit) begin
      @(negedge clock);
      n++;
      got_done = on_b ? b_tx_done : a_tx_done;
      got_fail = on_b ? b_tx_fail : a_tx_fail;
    end
    checkOutput(name, {got_done, got_fail}, want_done ? 2'b10 : 2'b01);
  endtask

  task automatic injectByte(input logic [7:0] value);
    logic [9:0] frame;
    frame = {1'b1, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      inject_line = frame[i];
      repeat (CPB - 1) @(negedge clock);
    end
  endtask

  initial begin
    logic [7:0] wire_byte;
    logic       stop_level;
    int t0, fe0, rx0, ack0, n, nv;
    logic [DW-1:0] wa, wb;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_uart_tx", a_uart_tx, 1'b1);
    checkOutput("rst_busy", {a_tx_busy, a_tx_done, a_tx_fail}, 3'b000);
    checkOutput("rst_rx", {b_ack_out, b_rx_valid, b_rx_frame_err}, 3'b000);
    checkOutput("rst_rx_data", b_rx_data, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // 1: single word, wire-level first byte and ack latency
    applyStimulus(0, 32'hDEADBEEF, 1);
    t0 = cyc;
    checkOutput("t1_start_bit", a_uart_tx, 1'b0);
    checkOutput("t1_busy", a_tx_busy, 1'b1);
    repeat (5) @(negedge clock);
    wire_byte[0] = a_uart_tx;
    for (int i = 1; i < 8; i++) begin
      repeat (CPB) @(negedge clock);
      wire_byte[i] = a_uart_tx;
    end
    repeat (CPB) @(negedge clock);
    stop_level = a_uart_tx;
    checkOutput("t1_wire_byte0", wire_byte, 8'hEF);
    checkOutput("t1_wire_stop", stop_level, 1'b1);
    waitDone(0, 1, 300, "t1_done");
    checkOutput("t1_done_latency_ok", ((cyc - t0) >= WORD_CYCLES) && ((cyc - t0) <= WORD_CYCLES + 12), 1'b1);
    checkOutput("t1_busy_after", a_tx_busy, 1'b0);
    checkOutput("t1_rx_count", b_rx_cnt, 1);
    repeat (20) @(negedge clock);

    // 2: ack wire cut -> MAX_RETRY+1 transmissions, then tx_fail
    ack_cut = 1'b1;
    rx0 = b_rx_cnt;
    applyStimulus(0, 32'h12345678, MR + 1);
    t0 = cyc;
    waitDone(0, 0, 1500, "t2_fail");
    checkOutput("t2_fail_time_ok", ((cyc - t0) >= (MR + 1) * ATTEMPT - 2) && ((cyc - t0) <= (MR + 1) * ATTEMPT + 2), 1'b1);
    @(negedge clock);
    checkOutput("t2_busy_after", a_tx_busy, 1'b0);
    checkOutput("t2_rx_count", b_rx_cnt - rx0, MR + 1);
    nv = b_valid_times.size();
    if (nv >= 3) begin
      checkOutput("t2_spacing1_ok", (b_valid_times[nv-2] - b_valid_times[nv-3]) == ATTEMPT, 1'b1);
      checkOutput("t2_spacing2_ok", (b_valid_times[nv-1] - b_valid_times[nv-2]) == ATTEMPT, 1'b1);
    end
    ack_cut = 1'b0;
    repeat (20) @(negedge clock);

    // 3: corrupt the stop bit of byte 2; sender retries and the clean copy arrives
    fe0 = b_fe_cnt; rx0 = b_rx_cnt; ack0 = b_ack_cnt;
    applyStimulus(0, 32'hFFA5C33C, 1);
    repeat (2 * 10 * CPB + 9 * CPB) @(negedge clock);
    force_low = 1'b1;
    repeat (CPB) @(negedge clock);
    force_low = 1'b0;
    n = 0;
    while (b_fe_cnt == fe0 && n < 50) begin @(negedge clock); n++; end
    repeat (100) @(negedge clock);
    checkOutput("t3_frame_err", b_fe_cnt - fe0, 1);
    checkOutput("t3_no_valid", b_rx_cnt - rx0, 0);
    checkOutput("t3_no_ack", b_ack_cnt - ack0, 0);
    waitDone(0, 1, 600, "t3_done_after_retry");
    checkOutput("t3_rx_count", b_rx_cnt - rx0, 1);
    checkOutput("t3_queue_empty", q_b.size(), 0);
    repeat (20) @(negedge clock);

    // 4: two raw bytes then silence -> gap timeout; next word intact
    fe0 = b_fe_cnt; rx0 = b_rx_cnt;
    inject_en = 1'b1;
    injectByte(8'h5A);
    injectByte(8'hC3);
    @(negedge clock);
    inject_line = 1'b1;
    repeat (100) @(negedge clock);
    checkOutput("t4_no_early_gap", b_fe_cnt - fe0, 0);
    repeat (GB * CPB + 1 - 100 + 30) @(negedge clock);
    checkOutput("t4_gap_err", b_fe_cnt - fe0, 1);
    checkOutput("t4_no_valid", b_rx_cnt - rx0, 0);
    inject_en = 1'b0;
    repeat (5) @(negedge clock);
    applyStimulus(0, 32'hCAFEF00D, 1);
    waitDone(0, 1, 300, "t4_done");
    checkOutput("t4_rx_count", b_rx_cnt - rx0, 1);
    repeat (20) @(negedge clock);

    // 5: reset mid-send / mid-receive
    applyStimulus(0, 32'h0BADC0DE, 0);
    repeat (60) @(negedge clock);
    reset = 1'b1;
    q_a.delete(); q_b.delete();
    @(negedge clock);
    checkOutput("t5_uart_tx", a_uart_tx, 1'b1);
    checkOutput("t5_tx_flags", {a_tx_busy, a_tx_done, a_tx_fail}, 3'b000);
    checkOutput("t5_rx_flags", {b_ack_out, b_rx_valid, b_rx_frame_err}, 3'b000);
    checkOutput("t5_rx_data", b_rx_data, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    fe0 = b_fe_cnt; rx0 = b_rx_cnt;
    repeat (10) @(negedge clock);
    applyStimulus(0, 32'h600DF00D, 1);
    waitDone(0, 1, 300, "t5_done");
    checkOutput("t5_rx_count", b_rx_cnt - rx0, 1);
    checkOutput("t5_no_frame_err", b_fe_cnt - fe0, 0);
    repeat (20) @(negedge clock);

    // 6: full duplex, second tx_wr while busy is ignored
    rx0 = b_rx_cnt; n = a_rx_cnt;
    fork
      applyStimulus(0, 32'hA5A55A5A, 1);
      applyStimulus(1, 32'h13579BDF, 1);
    join
    repeat (10) @(negedge clock);
    checkOutput("t6_busy", a_tx_busy, 1'b1);
    applyStimulus(0, 32'h99999999, 0);
    fork
      waitDone(0, 1, 400, "t6_a_done");
      waitDone(1, 1, 400, "t6_b_done");
    join
    repeat (250) @(negedge clock);
    checkOutput("t6_b_count", b_rx_cnt - rx0, 1);
    checkOutput("t6_a_count", a_rx_cnt - n, 1);

    // Randomised full-duplex traffic
    for (int r = 0; r < 6; r++) begin
      wa = $urandom;
      wb = $urandom;
      n = $urandom_range(0, 40);
      fork
        applyStimulus(0, wa, 1);
        begin repeat (n) @(negedge clock); applyStimulus(1, wb, 1); end
      join
      fork
        waitDone(0, 1, 600, "rnd_a_done");
        waitDone(1, 1, 600, "rnd_b_done");
      join
      repeat ($urandom_range(5, 30)) @(negedge clock);
    end
    repeat (20) @(negedge clock);
    checkOutput("end_qa_empty", q_a.size(), 0);
    checkOutput("end_qb_empty", q_b.size(), 0);
    checkOutput("end_a_frame_err", a_fe_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #(500000);
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
